// File: rtl/char_terminal.sv
// Text-mode terminal: accepts a byte stream, interprets control codes, scrolls
// through a circular row offset and renders cells to RGB via an external font ROM.
module char_terminal #(
    parameter int          CLK_FREQ          = 50_000_000,
    parameter int          CHAR_HORZ_CNT     = 80,
    parameter int          CHAR_VERT_CNT     = 30,
    parameter int          CHAR_HORZ_PX_SIZE = 8,
    parameter int          CHAR_VERT_PX_SIZE = 16,
    parameter int          PIXEL_HPOS_W      = 10,
    parameter int          PIXEL_VPOS_W      = 9,
    parameter int          W_COLOR           = 4,
    parameter logic [7:0]  DEFAULT_ATTR      = 8'h07,
    parameter int          CURSOR_BLINK_FREQ = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [7:0]                           in_char,
    input  logic [7:0]                           in_attr,
    input  logic                                 cursor_en,
    output logic [$clog2(CHAR_HORZ_CNT)-1:0]     cursor_hpos,
    output logic [$clog2(CHAR_VERT_CNT)-1:0]     cursor_vpos,
    input  logic [PIXEL_HPOS_W-1:0]              pixel_hpos,
    input  logic [PIXEL_VPOS_W-1:0]              pixel_vpos,
    input  logic                                 display_on,
    output logic [7:0]                           font_char,
    output logic [$clog2(CHAR_VERT_PX_SIZE)-1:0] font_row,
    input  logic [CHAR_HORZ_PX_SIZE-1:0]         font_bits,
    output logic [W_COLOR-1:0]                   red,
    output logic [W_COLOR-1:0]                   green,
    output logic [W_COLOR-1:0]                   blue
);

    localparam int COL_W   = $clog2(CHAR_HORZ_CNT);
    localparam int ROW_W   = $clog2(CHAR_VERT_CNT);
    localparam int CELLS   = CHAR_HORZ_CNT * CHAR_VERT_CNT;
    localparam int ADDR_W  = $clog2(CELLS);
    localparam int FROW_W  = $clog2(CHAR_VERT_PX_SIZE);
    localparam int FCOL_W  = $clog2(CHAR_HORZ_PX_SIZE);
    localparam int BLINK_P = CLK_FREQ / CURSOR_BLINK_FREQ;
    localparam int BLINK_W = $clog2(BLINK_P + 1);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_char/in_attr are sampled on that edge. in_ready is high only in S_IDLE.
    typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_CLEAR_LINE} state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic [COL_W-1:0]   cur_col_q;
    logic [ROW_W-1:0]   cur_row_q;
    logic [ROW_W-1:0]   top_q;
    logic [ROW_W-1:0]   line_q;
    logic [ADDR_W-1:0]  clr_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;

    logic [15:0]        mem_q [CELLS];
    logic [15:0]        rd_data_q;

    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r,
                                                  input logic [ROW_W-1:0] t);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (ROW_W+1)'(CHAR_VERT_CNT))
            s = s - (ROW_W+1)'(CHAR_VERT_CNT);
        return s[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] pr,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(pr) * ADDR_W'(CHAR_HORZ_CNT) + ADDR_W'(c);
    endfunction

    function automatic logic [W_COLOR-1:0] chan(input logic b, input logic i);
        if (!b)
            return '0;
        else if (i)
            return '1;
        else
            return {1'b1, {(W_COLOR-1){1'b0}}};
    endfunction

    logic accept, is_print, is_lf, is_cr, is_bs, is_ff;
    logic col_last, row_last, row_adv;
    logic [ROW_W-1:0] next_top;

    assign accept   = in_valid && in_ready_q;
    assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign is_lf    = (in_char == 8'h0A);
    assign is_cr    = (in_char == 8'h0D);
    assign is_bs    = (in_char == 8'h08);
    assign is_ff    = (in_char == 8'h0C);
    assign col_last = (cur_col_q == COL_W'(CHAR_HORZ_CNT - 1));
    assign row_last = (cur_row_q == ROW_W'(CHAR_VERT_CNT - 1));
    assign row_adv  = (is_print && col_last) || is_lf;
    assign next_top = (top_q == ROW_W'(CHAR_VERT_CNT - 1)) ? '0 : top_q + 1'b1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = {8'h20, DEFAULT_ATTR};
        case (state_q)
            S_CLEAR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
            end
            S_CLEAR_LINE: begin
                wr_en   = 1'b1;
                wr_addr = cell_addr(line_q, clr_cnt_q[COL_W-1:0]);
            end
            default: begin
                if (accept && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(phys_row(cur_row_q, top_q), cur_col_q);
                    wr_data = {in_char, in_attr};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR_ALL;
            in_ready_q <= 1'b0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            top_q      <= '0;
            line_q     <= '0;
            clr_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_CLEAR_ALL: begin
                    if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        clr_cnt_q  <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                S_CLEAR_LINE: begin
                    if (clr_cnt_q == ADDR_W'(CHAR_HORZ_CNT - 1)) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        clr_cnt_q  <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_print)
                            cur_col_q <= col_last ? '0 : cur_col_q + 1'b1;
                        if (is_lf || is_cr)
                            cur_col_q <= '0;
                        if (is_bs && (cur_col_q != '0))
                            cur_col_q <= cur_col_q - 1'b1;
                        if (row_adv) begin
                            if (row_last) begin
                                // The row leaving the top becomes the new bottom row.
                                top_q      <= next_top;
                                line_q     <= top_q;
                                state_q    <= S_CLEAR_LINE;
                                in_ready_q <= 1'b0;
                                clr_cnt_q  <= '0;
                            end else begin
                                cur_row_q <= cur_row_q + 1'b1;
                            end
                        end
                        if (is_ff) begin
                            cur_col_q  <= '0;
                            cur_row_q  <= '0;
                            top_q      <= '0;
                            state_q    <= S_CLEAR_ALL;
                            in_ready_q <= 1'b0;
                            clr_cnt_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_P - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    logic [PIXEL_HPOS_W-1:0] px_col;
    logic [PIXEL_VPOS_W-1:0] px_row;
    logic                    in_grid, cur_match;
    logic [ADDR_W-1:0]       rd_addr;

    assign px_col    = pixel_hpos / PIXEL_HPOS_W'(CHAR_HORZ_PX_SIZE);
    assign px_row    = pixel_vpos / PIXEL_VPOS_W'(CHAR_VERT_PX_SIZE);
    assign in_grid   = (px_col < PIXEL_HPOS_W'(CHAR_HORZ_CNT)) &&
                       (px_row < PIXEL_VPOS_W'(CHAR_VERT_CNT));
    assign cur_match = in_grid && (px_col[COL_W-1:0] == cur_col_q) &&
                       (px_row[ROW_W-1:0] == cur_row_q);
    assign rd_addr   = in_grid ? cell_addr(phys_row(px_row[ROW_W-1:0], top_q),
                                           px_col[COL_W-1:0]) : '0;

    // Read-before-write ordering gives old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_addr] <= wr_data;
        rd_data_q <= mem_q[rd_addr];
    end

    logic [FROW_W-1:0] font_row_q;
    logic [FCOL_W-1:0] bit_s1_q, bit_s2_q;
    logic              on_s1_q, on_s2_q, inv_s1_q, inv_s2_q;
    logic [7:0]        attr_s2_q;
    logic [W_COLOR-1:0] red_q, green_q, blue_q;
    logic [3:0]        fg, bg, nib;
    logic              pix;

    assign pix = font_bits[FCOL_W'(CHAR_HORZ_PX_SIZE - 1) - bit_s2_q];
    assign fg  = inv_s2_q ? attr_s2_q[7:4] : attr_s2_q[3:0];
    assign bg  = inv_s2_q ? attr_s2_q[3:0] : attr_s2_q[7:4];
    assign nib = pix ? fg : bg;

    always_ff @(posedge clk) begin
        if (rst) begin
            font_row_q <= '0;
            bit_s1_q   <= '0;
            bit_s2_q   <= '0;
            on_s1_q    <= 1'b0;
            on_s2_q    <= 1'b0;
            inv_s1_q   <= 1'b0;
            inv_s2_q   <= 1'b0;
            attr_s2_q  <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            font_row_q <= FROW_W'(pixel_vpos % PIXEL_VPOS_W'(CHAR_VERT_PX_SIZE));
            bit_s1_q   <= FCOL_W'(pixel_hpos % PIXEL_HPOS_W'(CHAR_HORZ_PX_SIZE));
            on_s1_q    <= display_on && in_grid;
            inv_s1_q   <= cursor_en && blink_q && cur_match;
            bit_s2_q   <= bit_s1_q;
            on_s2_q    <= on_s1_q;
            inv_s2_q   <= inv_s1_q;
            attr_s2_q  <= rd_data_q[7:0];
            red_q      <= on_s2_q ? chan(nib[2], nib[3]) : '0;
            green_q    <= on_s2_q ? chan(nib[1], nib[3]) : '0;
            blue_q     <= on_s2_q ? chan(nib[0], nib[3]) : '0;
        end
    end

    assign in_ready    = in_ready_q;
    assign cursor_hpos = cur_col_q;
    assign cursor_vpos = cur_row_q;
    assign font_char   = rd_data_q[15:8];
    assign font_row    = font_row_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_char_terminal.sv
// Directed bench for char_terminal on a 4x3 grid with a short blink period and
// a small registered font ROM model (space = solid glyph, others = left column).
module tb_char_terminal;

    localparam int H = 4;
    localparam int V = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic [7:0] in_attr = 8'h00;
    logic       cursor_en = 1'b0;
    logic       in_ready;
    logic [1:0] cursor_hpos, cursor_vpos;
    logic [9:0] pixel_hpos = '0;
    logic [8:0] pixel_vpos = '0;
    logic       display_on = 1'b0;
    logic [7:0] font_char;
    logic [3:0] font_row;
    logic [7:0] font_bits = 8'h00;
    logic [3:0] red, green, blue;

    int checks = 0;
    int errors = 0;

    char_terminal #(
        .CLK_FREQ(8), .CHAR_HORZ_CNT(H), .CHAR_VERT_CNT(V),
        .CHAR_HORZ_PX_SIZE(8), .CHAR_VERT_PX_SIZE(16),
        .PIXEL_HPOS_W(10), .PIXEL_VPOS_W(9), .W_COLOR(4),
        .DEFAULT_ATTR(8'h07), .CURSOR_BLINK_FREQ(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_attr(in_attr), .cursor_en(cursor_en),
        .cursor_hpos(cursor_hpos), .cursor_vpos(cursor_vpos),
        .pixel_hpos(pixel_hpos), .pixel_vpos(pixel_vpos), .display_on(display_on),
        .font_char(font_char), .font_row(font_row), .font_bits(font_bits),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        font_bits <= (font_char == 8'h20) ? 8'hFF : 8'h80;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        d;
        logic        chk_font;
        logic [7:0]  font;
        logic [11:0] rgb;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cur(input string name, input logic [1:0] h, input logic [1:0] v);
        check(name, {28'd0, cursor_hpos, cursor_vpos}, {28'd0, h, v});
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_char  = c;
        in_attr  = a;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic probe(input logic [9:0] x, input logic [8:0] y, input logic d);
        pixel_hpos = x;
        pixel_vpos = y;
        display_on = d;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n, nrm, inv;

        vt[0]  = '{10'd0,  9'd0,  1'b1, 1'b1, 8'h41, 12'hF00};
        vt[1]  = '{10'd8,  9'd3,  1'b1, 1'b1, 8'h42, 12'hF00};
        vt[2]  = '{10'd9,  9'd0,  1'b1, 1'b1, 8'h42, 12'h008};
        vt[3]  = '{10'd15, 9'd15, 1'b1, 1'b1, 8'h42, 12'h008};
        vt[4]  = '{10'd16, 9'd0,  1'b1, 1'b1, 8'h43, 12'hFF0};
        vt[5]  = '{10'd17, 9'd0,  1'b1, 1'b1, 8'h43, 12'h008};
        vt[6]  = '{10'd24, 9'd0,  1'b1, 1'b1, 8'h20, 12'h888};
        vt[7]  = '{10'd8,  9'd0,  1'b0, 1'b1, 8'h42, 12'h000};
        vt[8]  = '{10'd32, 9'd0,  1'b1, 1'b0, 8'h00, 12'h000};
        vt[9]  = '{10'd0,  9'd48, 1'b1, 1'b0, 8'h00, 12'h000};
        vt[10] = '{10'd0,  9'd16, 1'b1, 1'b1, 8'h20, 12'h888};

        // Reset and full clear
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rgb_in_reset", {20'd0, red, green, blue}, 32'd0);
        check("ready_in_reset", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        count_busy(n);
        check("reset_clear_cycles", n, 12);
        check_cur("reset_cursor", 2'd0, 2'd0);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                probe(10'(c * 8 + 3), 9'(r * 16 + 5), 1'b1);
                check("clr_font", {24'd0, font_char}, 32'h20);
                check("clr_row", {28'd0, font_row}, 32'd5);
                check("clr_rgb", {20'd0, red, green, blue}, 32'h888);
            end
        end

        // Printable writes and pixel vectors
        send(8'h41, 8'h1C);
        send(8'h42, 8'h1C);
        check_cur("cursor_after_AB", 2'd2, 2'd0);
        send(8'h43, 8'h1E);
        check_cur("cursor_after_C", 2'd3, 2'd0);
        for (int i = 0; i < 11; i++) begin
            probe(vt[i].x, vt[i].y, vt[i].d);
            if (vt[i].chk_font)
                check($sformatf("vec%0d_font", i), {24'd0, font_char}, {24'd0, vt[i].font});
            check($sformatf("vec%0d_rgb", i), {20'd0, red, green, blue}, {20'd0, vt[i].rgb});
        end

        // Control codes
        send(8'h0D, 8'h00);
        check_cur("cr_at_col3", 2'd0, 2'd0);
        send(8'h08, 8'h00);
        check_cur("bs_at_col0", 2'd0, 2'd0);
        send(8'h01, 8'h00);
        check_cur("ignored_code", 2'd0, 2'd0);
        send(8'h0A, 8'h00);
        check_cur("lf_no_scroll", 2'd0, 2'd1);
        send(8'h5A, 8'h07);
        check_cur("char_row1", 2'd1, 2'd1);
        send(8'h08, 8'h00);
        check_cur("bs_at_col1", 2'd0, 2'd1);
        probe(10'd0, 9'd16, 1'b1);
        check("z_font", {24'd0, font_char}, 32'h5A);

        send(8'h0C, 8'h00);
        count_busy(n);
        check("ff_clear_cycles", n, 12);
        check_cur("ff_cursor", 2'd0, 2'd0);
        probe(10'd0, 9'd0, 1'b1);
        check("ff_cell00", {24'd0, font_char}, 32'h20);
        probe(10'd0, 9'd16, 1'b1);
        check("ff_cell01", {24'd0, font_char}, 32'h20);

        // Fill the grid; the 12th byte wraps and scrolls
        for (int i = 0; i < 11; i++)
            send(8'(8'h61 + i), 8'h07);
        check_cur("cursor_before_scroll", 2'd3, 2'd2);
        send(8'h6C, 8'h07);
        count_busy(n);
        check("scroll_busy_cycles", n, 4);
        check_cur("cursor_after_scroll", 2'd0, 2'd2);
        probe(10'd0, 9'd0, 1'b1);
        check("scroll_row0_font", {24'd0, font_char}, 32'h65);
        check("scroll_row0_rgb", {20'd0, red, green, blue}, 32'h888);
        probe(10'd1, 9'd0, 1'b1);
        check("scroll_row0_bg", {20'd0, red, green, blue}, 32'h000);
        probe(10'd24, 9'd16, 1'b1);
        check("scroll_row1_font", {24'd0, font_char}, 32'h6C);
        for (int c = 0; c < H; c++) begin
            probe(10'(c * 8 + 4), 9'd40, 1'b1);
            check("scroll_bottom_font", {24'd0, font_char}, 32'h20);
            check("scroll_bottom_rgb", {20'd0, red, green, blue}, 32'h888);
        end

        // LF on the bottom row scrolls again
        send(8'h0A, 8'h00);
        count_busy(n);
        check("lf_scroll_busy", n, 4);
        check_cur("lf_scroll_cursor", 2'd0, 2'd2);
        probe(10'd0, 9'd0, 1'b1);
        check("lf_scroll_row0", {24'd0, font_char}, 32'h69);
        probe(10'd8, 9'd32, 1'b1);
        check("lf_scroll_row2", {24'd0, font_char}, 32'h20);

        // Reset in the middle of a clear restarts the full clear
        send(8'h0C, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("midclear_reset_cycles", n, 12);
        check_cur("midclear_reset_cursor", 2'd0, 2'd0);

        // Cursor blink: 8-cycle phase, so any 16 samples split evenly
        cursor_en = 1'b1;
        probe(10'd2, 9'd2, 1'b1);
        nrm = 0;
        inv = 0;
        for (int i = 0; i < 16; i++) begin
            if ({red, green, blue} == 12'h888) nrm++;
            else if ({red, green, blue} == 12'h000) inv++;
            @(negedge clk);
        end
        check("blink_normal_count", nrm, 8);
        check("blink_swapped_count", inv, 8);
        probe(10'd10, 9'd2, 1'b1);
        nrm = 0;
        for (int i = 0; i < 16; i++) begin
            if ({red, green, blue} == 12'h888) nrm++;
            @(negedge clk);
        end
        check("blink_other_cell", nrm, 16);
        probe(10'd2, 9'd2, 1'b0);
        check("display_off_rgb", {20'd0, red, green, blue}, 32'd0);
        cursor_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
